// File: rtl/bias_act_unit_pkg.sv
// Shared types and constants for the bias + activation post-processing stage.
// Holds the FSM encoding, activation mode codes and default DRAM region bases.
package bias_act_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LD_PARAM = 3'd1,
    ST_LD_BIAS  = 3'd2,
    ST_EVAL     = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [1:0] ACT_BYPASS = 2'd0;
  localparam logic [1:0] ACT_RELU   = 2'd1;
  localparam logic [1:0] ACT_LEAKY  = 2'd2;

  localparam int DEF_PARAM_BASE = 0;
  localparam int DEF_BIAS_BASE  = 61504;
  localparam int DEF_FMAP_BASE  = 131072;
  localparam int DEF_OUT_BASE   = 131072;

  // width, height, depth words
  localparam int N_PARAM_WORDS = 3;

endpackage

// File: rtl/bias_act_unit_act_sat.sv
// Combinational saturating bias add followed by the selected activation.
// Mode 3 is not a distinct code and falls through to ReLU.
module bias_act_unit_act_sat
  import bias_act_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [DATA_WIDTH-1:0] pixel,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0]   sum_wide;
  logic [DATA_WIDTH-1:0] sat;

  always_comb begin
    sum_wide = {pixel[DATA_WIDTH-1], pixel} + {bias[DATA_WIDTH-1], bias};
    // The two top bits disagree exactly when the signed sum left the DATA_WIDTH range.
    if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
      sat = sum_wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sat = sum_wide[DATA_WIDTH-1:0];
    end

    result = sat;
    case (mode)
      ACT_BYPASS: result = sat;
      ACT_LEAKY: begin
        if (sat[DATA_WIDTH-1]) result = $unsigned($signed(sat) >>> LEAK_SHIFT);
      end
      default: begin
        if (sat[DATA_WIDTH-1]) result = '0;
      end
    endcase
  end

endmodule

// File: rtl/bias_act_unit.sv
// Bias + activation stage: loads layer params and biases from DRAM, then streams
// every pixel through act_sat and writes it to the output region.
module bias_act_unit
  import bias_act_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int DIM_WIDTH  = 6,
  parameter int KNL_MAXNUM = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int PARAM_BASE = DEF_PARAM_BASE,
  parameter int BIAS_BASE  = DEF_BIAS_BASE,
  parameter int FMAP_BASE  = DEF_FMAP_BASE,
  parameter int OUT_BASE   = DEF_OUT_BASE
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  param_err,
  output logic                  done,
  output state_t                dbg_state
);

  // Read handshake: a request is accepted in any cycle with dram_en_rd & dram_valid;
  // only then do address and counters move. acc_ff marks that data_in carries the
  // answer to that request in the following cycle. The write port never stalls.

  localparam int DEP_W = $clog2(KNL_MAXNUM + 1);
  localparam int IDX_W = $clog2(KNL_MAXNUM);

  localparam logic [ADDR_WIDTH-1:0] PARAM_A = ADDR_WIDTH'(PARAM_BASE);
  localparam logic [ADDR_WIDTH-1:0] BIAS_A  = ADDR_WIDTH'(BIAS_BASE);
  localparam logic [ADDR_WIDTH-1:0] FMAP_A  = ADDR_WIDTH'(FMAP_BASE);
  localparam logic [ADDR_WIDTH-1:0] OUT_A   = ADDR_WIDTH'(OUT_BASE);

  state_t                state_q, state_d;
  logic [1:0]            mode_q;
  logic [DIM_WIDTH-1:0]  width_q, height_q, w_q, h_q;
  logic [DEP_W-1:0]      depth_q;
  logic [IDX_W-1:0]      d_q, chan_ff;
  logic [ADDR_WIDTH-1:0] ptr_q, idx_ff, rd_base, depth_a;
  logic                  acc_ff, param_err_q;
  logic                  accept, param_bad, w_wrap, h_wrap, last_pix;
  logic [DATA_WIDTH-1:0] bias_rf [KNL_MAXNUM];
  logic [DATA_WIDTH-1:0] act_result;

  assign accept    = dram_en_rd & dram_valid;
  assign depth_a   = ADDR_WIDTH'(depth_q);
  assign w_wrap    = (w_q == width_q - DIM_WIDTH'(1));
  assign h_wrap    = (h_q == height_q - DIM_WIDTH'(1));
  assign last_pix  = w_wrap && h_wrap && (DEP_W'(d_q) == depth_q - DEP_W'(1));
  // Evaluated while the depth word is on data_in; width/height are already captured.
  assign param_bad = (width_q == '0) || (height_q == '0) || (data_in == '0) ||
                     (data_in > DATA_WIDTH'(KNL_MAXNUM));

  always_ff @(posedge clk) begin
    if (srst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    dram_en_rd = 1'b0;
    rd_base    = PARAM_A;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_LD_PARAM;
      end
      ST_LD_PARAM: begin
        dram_en_rd = (ptr_q < ADDR_WIDTH'(N_PARAM_WORDS));
        if (acc_ff && idx_ff == ADDR_WIDTH'(N_PARAM_WORDS - 1)) begin
          state_d = param_bad ? ST_DONE : ST_LD_BIAS;
        end
      end
      ST_LD_BIAS: begin
        rd_base    = BIAS_A;
        dram_en_rd = (ptr_q < depth_a);
        if (acc_ff && idx_ff == depth_a - ADDR_WIDTH'(1)) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        rd_base    = FMAP_A;
        dram_en_rd = 1'b1;
        if (dram_valid && last_pix) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (acc_ff) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      mode_q      <= '0;
      width_q     <= '0;
      height_q    <= '0;
      depth_q     <= '0;
      w_q         <= '0;
      h_q         <= '0;
      d_q         <= '0;
      ptr_q       <= '0;
      idx_ff      <= '0;
      chan_ff     <= '0;
      acc_ff      <= 1'b0;
      param_err_q <= 1'b0;
      for (int i = 0; i < KNL_MAXNUM; i++) bias_rf[i] <= '0;
    end else begin
      acc_ff <= accept;
      if (accept) begin
        idx_ff  <= ptr_q;
        chan_ff <= d_q;
        ptr_q   <= ptr_q + ADDR_WIDTH'(1);
        if (state_q == ST_EVAL) begin
          // w fastest, then h, then channel; linear ptr stays equal to d*H*W + h*W + w
          if (w_wrap) begin
            w_q <= '0;
            if (h_wrap) begin
              h_q <= '0;
              d_q <= d_q + IDX_W'(1);
            end else begin
              h_q <= h_q + DIM_WIDTH'(1);
            end
          end else begin
            w_q <= w_q + DIM_WIDTH'(1);
          end
        end
      end

      if (acc_ff && state_q == ST_LD_PARAM) begin
        case (idx_ff)
          ADDR_WIDTH'(0): width_q  <= data_in[DIM_WIDTH-1:0];
          ADDR_WIDTH'(1): height_q <= data_in[DIM_WIDTH-1:0];
          default: begin
            depth_q <= data_in[DEP_W-1:0];
            if (param_bad) param_err_q <= 1'b1;
          end
        endcase
      end
      if (acc_ff && state_q == ST_LD_BIAS) bias_rf[idx_ff[IDX_W-1:0]] <= data_in;

      // Each phase starts its pointer and pixel counters from zero.
      if (state_d != state_q) begin
        ptr_q <= '0;
        w_q   <= '0;
        h_q   <= '0;
        d_q   <= '0;
      end

      if (state_q == ST_IDLE && enable) begin
        mode_q      <= mode;
        param_err_q <= 1'b0;
      end
    end
  end

  bias_act_unit_act_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_act_sat (
    .pixel  (data_in),
    .bias   (bias_rf[chan_ff]),
    .mode   (mode_q),
    .result (act_result)
  );

  assign dram_en_wr = acc_ff && (state_q == ST_EVAL || state_q == ST_DRAIN);
  assign addr_in    = dram_en_rd ? rd_base + ptr_q : '0;
  assign addr_out   = dram_en_wr ? OUT_A + idx_ff : '0;
  assign data_out   = dram_en_wr ? act_result : '0;
  assign param_err  = param_err_q;
  assign done       = (state_q == ST_DONE);
  assign dbg_state  = state_q;

endmodule
